mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter W, default `WORD_WIDTH (32), data/address width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low (rst==0 resets on the next clk edge).
REQ-004 valid_in, reg_write, mem_read, mem_write  in  1 each  EX/MEM instruction valid and control bits.
REQ-005 mem_op  in  `MEM_OP_W (3)  access size/sign: B=000, H=001, W=010, BU=100, HU=101.
REQ-006 alu_result, store_data, pc  in  W  address or ALU result; store data; instruction PC.
REQ-007 rd, rt  in  `REG_ADDR_W; reg_write_src  in  `REG_W_SRC_WIDTH; reg_write_dst  in  `REG_W_DST_WIDTH.
REQ-008 stall  out  1  upstream hold; instruction inputs are ignored while 1.
REQ-009 dmem_req, dmem_we  out  1; dmem_addr  out  W (bits 1:0 = 0); dmem_be  out  4; dmem_wdata  out  W.
REQ-010 dmem_ack  in  1; dmem_rdata  in  W  word-aligned read data, valid in the ack cycle.
REQ-011 wb_valid, wb_reg_write, addr_err  out  1  registered MEM/WB outputs.
REQ-012 wb_alu_result, wb_mem_data, wb_pc  out  W; wb_rd, wb_rt, wb_reg_write_src, wb_reg_write_dst  out  as inputs.

Function
REQ-013 FSM states: IDLE, BUSY; stall SHALL equal (state==BUSY), combinationally.
REQ-014 IDLE, valid_in=0: next edge loads a bubble (wb_valid=0, wb_reg_write=0, addr_err=0).
REQ-015 IDLE, valid_in=1, no memory op: next edge loads all wb_* from inputs; wb_valid=1, wb_mem_data=0; latency 1.
REQ-016 mem_read and mem_write both set: treat as mem_write only.
REQ-017 Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0): no memory request; next edge loads wb_valid=1, wb_reg_write=0, addr_err=1, other wb_* from inputs.
REQ-018 Aligned memory op in IDLE: capture instruction, go BUSY; next edge loads a bubble; dmem_req=1 from the first BUSY cycle.
REQ-019 dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL be registered and stable from request assertion through the ack cycle inclusive.
REQ-020 BUSY with dmem_ack=1: next edge loads the captured instruction with wb_valid=1 and the load data if a read; state returns to IDLE; dmem_req=0.
REQ-021 BUSY with dmem_ack=0: hold all state; WB holds a bubble; no timeout.
REQ-022 dmem_ack while IDLE SHALL be ignored.
REQ-023 Byte lane = addr[1:0], little-endian (lane 0 = bits 7:0); halfword lane = addr[1].
REQ-024 Loads: B/H sign-extend, BU/HU zero-extend, W passes dmem_rdata.
REQ-025 Stores: B -> be=1<<addr[1:0], wdata = byte replicated x4; H -> be=0011/1100, halfword replicated x2; W -> be=1111.
REQ-026 Reads: dmem_we=0, dmem_be=1111.
REQ-027 An instruction accepted while stall=1 is impossible: the upstream instruction is taken only in IDLE.

Reset
REQ-028 On rst==0 at an edge: state=IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
REQ-029 On rst==0 at an edge: all wb_* = 0, addr_err=0.
REQ-030 Reset in BUSY aborts the access; a late dmem_ack is ignored per REQ-022.

Structure
REQ-031 `MEM_OP_W and the `MEM_OP_* codes SHALL be added to defines.v beside the existing `REG_W_SRC_*/`REG_W_DST_* codes.
REQ-032 Lane select, load extension and store replication/be generation SHALL live in one combinational sub-module, mem_align.

Verification
REQ-033 ALU op, alu_result=0x1234, reg_write=1 -> next cycle wb_valid=1, wb_alu_result=0x1234, stall never 1.
REQ-034 LB addr=0x103, ack after 2 wait cycles, rdata=0x80FFFFFF -> dmem_addr=0x100, stall 3 cycles, wb_mem_data=0xFFFFFF80.
REQ-035 LHU addr=0x102, rdata=0xBEEF1234 -> wb_mem_data=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-036 SB addr=0x201, store_data=0xAB -> dmem_we=1, be=0010, wdata=0xABABABAB, wb_reg_write=0.
REQ-037 LW addr=0x102 -> dmem_req stays 0, addr_err=1 for one cycle, wb_reg_write=0.
REQ-038 rst=0 during BUSY, then ack next cycle -> dmem_req=0, state IDLE, wb_valid stays 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-op encodings, FSM state codes and the captured-instruction
// control bundle used by the MEM stage and its alignment helper.
package mem_stage_pkg;

    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned MEM_OP_W        = 3;
    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned REG_W_SRC_WIDTH = 2;
    localparam int unsigned REG_W_DST_WIDTH = 2;

    // Access size in bits 1:0, bit 2 selects zero-extension on loads.
    localparam logic [MEM_OP_W-1:0] MEM_OP_B  = 3'b000;
    localparam logic [MEM_OP_W-1:0] MEM_OP_H  = 3'b001;
    localparam logic [MEM_OP_W-1:0] MEM_OP_W_ = 3'b010;
    localparam logic [MEM_OP_W-1:0] MEM_OP_BU = 3'b100;
    localparam logic [MEM_OP_W-1:0] MEM_OP_HU = 3'b101;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Control fields that travel with an instruction from EX/MEM to MEM/WB.
    typedef struct packed {
        logic                       reg_write;
        logic                       mem_read;
        logic [MEM_OP_W-1:0]        mem_op;
        logic [REG_ADDR_W-1:0]      rd;
        logic [REG_ADDR_W-1:0]      rt;
        logic [REG_W_SRC_WIDTH-1:0] reg_write_src;
        logic [REG_W_DST_WIDTH-1:0] reg_write_dst;
    } ctrl_t;

    function automatic logic [1:0] op_size(input logic [MEM_OP_W-1:0] op);
        return op[1:0];
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage.
//   op_i          access size/sign code
//   addr_lo_i     low two address bits (byte lane)
//   is_write_i    store access (reads always enable all four lanes)
//   store_data_i  register data to store; wdata_o is it replicated across lanes
//   rdata_i       word-aligned read data; load_data_o is the extended lane
//   misaligned_o  halfword on odd address or word on non-multiple-of-4 address
//   be_o          byte enables, lane 0 = bits 7:0
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned W = WORD_WIDTH
) (
    input  logic [MEM_OP_W-1:0] op_i,
    input  logic [1:0]          addr_lo_i,
    input  logic                is_write_i,
    input  logic [W-1:0]        store_data_i,
    input  logic [W-1:0]        rdata_i,
    output logic                misaligned_o,
    output logic [3:0]          be_o,
    output logic [W-1:0]        wdata_o,
    output logic [W-1:0]        load_data_o
);

    logic [4:0]  byte_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_shift   = {addr_lo_i, 3'b000};
        byte_sel     = rdata_i[byte_shift +: 8];
        half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        load_data_o  = rdata_i;

        case (op_size(op_i))
            2'b00: begin
                if (is_write_i) begin
                    be_o = 4'b0001 << addr_lo_i;
                end
                wdata_o     = {(W/8){store_data_i[7:0]}};
                load_data_o = op_i[2] ? {{(W-8){1'b0}}, byte_sel}
                                      : {{(W-8){byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                misaligned_o = addr_lo_i[0];
                if (is_write_i) begin
                    be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                end
                wdata_o     = {(W/16){store_data_i[15:0]}};
                load_data_o = op_i[2] ? {{(W-16){1'b0}}, half_sel}
                                      : {{(W-16){half_sel[15]}}, half_sel};
            end
            // Word, and any unassigned size code, is handled as a full word.
            default: begin
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store and waits for
// the ack, holding the pipeline via stall meanwhile; produces registered MEM/WB.
//   clk, rst                synchronous active-low reset
//   valid_in, reg_write, mem_read, mem_write, mem_op, alu_result, store_data, pc,
//   rd, rt, reg_write_src, reg_write_dst     EX/MEM instruction (taken in IDLE only)
//   stall                   high while an access is outstanding
//   dmem_*                  registered request, stable until and including ack
//   wb_*, addr_err          registered MEM/WB outputs
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned W = WORD_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic                       reg_write,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [MEM_OP_W-1:0]        mem_op,
    input  logic [W-1:0]               alu_result,
    input  logic [W-1:0]               store_data,
    input  logic [W-1:0]               pc,
    input  logic [REG_ADDR_W-1:0]      rd,
    input  logic [REG_ADDR_W-1:0]      rt,
    input  logic [REG_W_SRC_WIDTH-1:0] reg_write_src,
    input  logic [REG_W_DST_WIDTH-1:0] reg_write_dst,
    output logic                       stall,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [W-1:0]               dmem_addr,
    output logic [3:0]                 dmem_be,
    output logic [W-1:0]               dmem_wdata,
    input  logic                       dmem_ack,
    input  logic [W-1:0]               dmem_rdata,
    output logic                       wb_valid,
    output logic                       wb_reg_write,
    output logic                       addr_err,
    output logic [W-1:0]               wb_alu_result,
    output logic [W-1:0]               wb_mem_data,
    output logic [W-1:0]               wb_pc,
    output logic [REG_ADDR_W-1:0]      wb_rd,
    output logic [REG_ADDR_W-1:0]      wb_rt,
    output logic [REG_W_SRC_WIDTH-1:0] wb_reg_write_src,
    output logic [REG_W_DST_WIDTH-1:0] wb_reg_write_dst
);

    logic [0:0] state_q, state_d;

    ctrl_t      in_ctrl;
    ctrl_t      cap_ctrl_q, cap_ctrl_d;
    logic [W-1:0] cap_alu_q, cap_alu_d;
    logic [W-1:0] cap_pc_q, cap_pc_d;

    logic         req_q, req_d;
    logic         we_q, we_d;
    logic [W-1:0] addr_q, addr_d;
    logic [3:0]   be_q, be_d;
    logic [W-1:0] wdata_q, wdata_d;

    logic         wb_valid_q, wb_valid_d;
    logic         wb_err_q, wb_err_d;
    ctrl_t        wb_ctrl_q, wb_ctrl_d;
    logic [W-1:0] wb_alu_q, wb_alu_d;
    logic [W-1:0] wb_mem_q, wb_mem_d;
    logic [W-1:0] wb_pc_q, wb_pc_d;

    logic                is_wr;
    logic                is_mem;
    logic [MEM_OP_W-1:0] al_op;
    logic [1:0]          al_addr;
    logic                al_we;
    logic                al_misaligned;
    logic [3:0]          al_be;
    logic [W-1:0]        al_wdata;
    logic [W-1:0]        al_load;

    // A store that also claims to be a load is treated as a store only.
    assign is_wr  = mem_write;
    assign is_mem = mem_read | mem_write;
    assign stall  = (state_q == ST_BUSY);

    always_comb begin
        in_ctrl               = '0;
        in_ctrl.reg_write     = reg_write;
        in_ctrl.mem_read      = mem_read & ~mem_write;
        in_ctrl.mem_op        = mem_op;
        in_ctrl.rd            = rd;
        in_ctrl.rt            = rt;
        in_ctrl.reg_write_src = reg_write_src;
        in_ctrl.reg_write_dst = reg_write_dst;
    end

    // One aligner serves both phases: the incoming instruction in IDLE (store lanes,
    // misalignment) and the captured one in BUSY (load extension).
    assign al_op   = stall ? cap_ctrl_q.mem_op : mem_op;
    assign al_addr = stall ? cap_alu_q[1:0] : alu_result[1:0];
    assign al_we   = stall ? 1'b0 : is_wr;

    mem_align #(
        .W (W)
    ) u_mem_align (
        .op_i         (al_op),
        .addr_lo_i    (al_addr),
        .is_write_i   (al_we),
        .store_data_i (store_data),
        .rdata_i      (dmem_rdata),
        .misaligned_o (al_misaligned),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load)
    );

    always_comb begin
        state_d    = state_q;
        cap_ctrl_d = cap_ctrl_q;
        cap_alu_d  = cap_alu_q;
        cap_pc_d   = cap_pc_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        // Bubble by default; payload fields hold their last value.
        wb_valid_d          = 1'b0;
        wb_err_d            = 1'b0;
        wb_ctrl_d           = wb_ctrl_q;
        wb_ctrl_d.reg_write = 1'b0;
        wb_alu_d            = wb_alu_q;
        wb_mem_d            = wb_mem_q;
        wb_pc_d             = wb_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (!is_mem || al_misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_ctrl_d  = in_ctrl;
                        wb_alu_d   = alu_result;
                        wb_mem_d   = '0;
                        wb_pc_d    = pc;
                        if (is_mem) begin
                            wb_err_d            = 1'b1;
                            wb_ctrl_d.reg_write = 1'b0;
                        end
                    end else begin
                        state_d    = ST_BUSY;
                        cap_ctrl_d = in_ctrl;
                        cap_alu_d  = alu_result;
                        cap_pc_d   = pc;
                        req_d      = 1'b1;
                        we_d       = is_wr;
                        addr_d     = {alu_result[W-1:2], 2'b00};
                        be_d       = al_be;
                        wdata_d    = al_wdata;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_ctrl_d  = cap_ctrl_q;
                    wb_alu_d   = cap_alu_q;
                    wb_mem_d   = cap_ctrl_q.mem_read ? al_load : '0;
                    wb_pc_d    = cap_pc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cap_ctrl_q <= '0;
            cap_alu_q  <= '0;
            cap_pc_q   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_ctrl_q  <= '0;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
            wb_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            cap_ctrl_q <= cap_ctrl_d;
            cap_alu_q  <= cap_alu_d;
            cap_pc_q   <= cap_pc_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_err_q   <= wb_err_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_alu_q   <= wb_alu_d;
            wb_mem_q   <= wb_mem_d;
            wb_pc_q    <= wb_pc_d;
        end
    end

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_be          = be_q;
    assign dmem_wdata       = wdata_q;
    assign wb_valid         = wb_valid_q;
    assign wb_reg_write     = wb_ctrl_q.reg_write;
    assign addr_err         = wb_err_q;
    assign wb_alu_result    = wb_alu_q;
    assign wb_mem_data      = wb_mem_q;
    assign wb_pc            = wb_pc_q;
    assign wb_rd            = wb_ctrl_q.rd;
    assign wb_rt            = wb_ctrl_q.rt;
    assign wb_reg_write_src = wb_ctrl_q.reg_write_src;
    assign wb_reg_write_dst = wb_ctrl_q.reg_write_dst;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected WB records, a negedge
// monitor pops and compares them whenever wb_valid is high.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0, reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] alu_result = '0, store_data = '0, pc = '0;
    logic [4:0]  rd = '0, rt = '0;
    logic [1:0]  reg_write_src = '0, reg_write_dst = '0;
    logic        stall, dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h5555_AAAA;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, addr_err;
    logic [31:0] wb_alu_result, wb_mem_data, wb_pc;
    logic [4:0]  wb_rd, wb_rt;
    logic [1:0]  wb_reg_write_src, wb_reg_write_dst;

    mem_stage #(.W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .reg_write        (reg_write),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_op           (mem_op),
        .alu_result       (alu_result),
        .store_data       (store_data),
        .pc               (pc),
        .rd               (rd),
        .rt               (rt),
        .reg_write_src    (reg_write_src),
        .reg_write_dst    (reg_write_dst),
        .stall            (stall),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .addr_err         (addr_err),
        .wb_alu_result    (wb_alu_result),
        .wb_mem_data      (wb_mem_data),
        .wb_pc            (wb_pc),
        .wb_rd            (wb_rd),
        .wb_rt            (wb_rt),
        .wb_reg_write_src (wb_reg_write_src),
        .wb_reg_write_dst (wb_reg_write_dst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic        rw;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every valid WB record against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_alu_result", wb_alu_result, mon_e.alu);
                    chk("wb_mem_data", wb_mem_data, mon_e.mdata);
                    chk("wb_pc", wb_pc, mon_e.pc);
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                    chk("wb_rt", {27'd0, wb_rt}, {27'd0, mon_e.rt});
                    chk("wb_src", {30'd0, wb_reg_write_src}, {30'd0, mon_e.src});
                    chk("wb_dst", {30'd0, wb_reg_write_dst}, {30'd0, mon_e.dst});
                    chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e.rw});
                    chk("wb_addr_err", {31'd0, addr_err}, {31'd0, mon_e.err});
                end
            end else begin
                chk("bubble_addr_err", {31'd0, addr_err}, 32'd0);
                chk("bubble_reg_write", {31'd0, wb_reg_write}, 32'd0);
            end
        end
    end

    // Issue one instruction (called #1 after a posedge); returns #1 after the
    // edge that takes it. Register fields are derived from pc.
    task automatic send(input logic rw, input logic mr, input logic mw, input logic [2:0] op,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] p,
                        input logic push, input logic [31:0] mdata, input logic err);
        exp_t e;
        int   guard = 0;
        while (stall && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (stall) chk("send_wait_stall", {31'd0, stall}, 32'd0);
        valid_in      = 1'b1;
        reg_write     = rw;
        mem_read      = mr;
        mem_write     = mw;
        mem_op        = op;
        alu_result    = alu;
        store_data    = sd;
        pc            = p;
        rd            = p[6:2];
        rt            = p[7:3];
        reg_write_src = p[3:2];
        reg_write_dst = p[5:4];
        if (push) begin
            e.alu   = alu;
            e.mdata = mdata;
            e.pc    = p;
            e.rd    = p[6:2];
            e.rt    = p[7:3];
            e.src   = p[3:2];
            e.dst   = p[5:4];
            e.rw    = err ? 1'b0 : rw;
            e.err   = err;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_in   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_result = 32'hFFFF_FFFF;
    endtask

    // Act as data memory: check the request, hold it for waits cycles, then ack.
    task automatic respond(input string tag, input int waits, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, output int stall_cyc);
        int guard = 0;
        while (!dmem_req && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        stall_cyc = 0;
        for (int i = 0; i <= waits; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                chk({tag, "_req_hold"}, {31'd0, dmem_req}, 32'd1);
            end
            chk({tag, "_addr"}, dmem_addr, e_addr);
            chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, e_we});
            chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, e_be});
            if (e_we) chk({tag, "_wdata"}, dmem_wdata, e_wdata);
            if (stall) stall_cyc++;
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h5555_AAAA;
        chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, "_stall_drop"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_alu", wb_alu_result, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU op: one-cycle latency, no stall.
        send(1'b1, 1'b0, 1'b0, MEM_OP_W_, 32'h0000_1234, 32'h0, 32'h40, 1'b1, 32'h0, 1'b0);
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_req", {31'd0, dmem_req}, 32'd0);

        // LB 0x103, two wait cycles.
        send(1'b1, 1'b1, 1'b0, MEM_OP_B, 32'h103, 32'h0, 32'h44, 1'b1, 32'hFFFF_FF80, 1'b0);
        respond("lb", 2, 32'h80FF_FFFF, 32'h100, 1'b0, 4'b1111, 32'h0, sc);
        chk("lb_stall_cycles", sc, 32'd3);

        // LHU / LH upper halfword.
        send(1'b1, 1'b1, 1'b0, MEM_OP_HU, 32'h102, 32'h0, 32'h48, 1'b1, 32'h0000_BEEF, 1'b0);
        respond("lhu", 0, 32'hBEEF_1234, 32'h100, 1'b0, 4'b1111, 32'h0, sc);
        send(1'b1, 1'b1, 1'b0, MEM_OP_H, 32'h102, 32'h0, 32'h4C, 1'b1, 32'hFFFF_BEEF, 1'b0);
        respond("lh", 1, 32'hBEEF_1234, 32'h100, 1'b0, 4'b1111, 32'h0, sc);

        // Stores.
        send(1'b0, 1'b0, 1'b1, MEM_OP_B, 32'h201, 32'h0000_00AB, 32'h50, 1'b1, 32'h0, 1'b0);
        respond("sb", 1, 32'h0, 32'h200, 1'b1, 4'b0010, 32'hABAB_ABAB, sc);
        send(1'b0, 1'b0, 1'b1, MEM_OP_H, 32'h206, 32'h1234_CDEF, 32'h54, 1'b1, 32'h0, 1'b0);
        respond("sh", 0, 32'h0, 32'h204, 1'b1, 4'b1100, 32'hCDEF_CDEF, sc);
        send(1'b0, 1'b0, 1'b1, MEM_OP_W_, 32'h208, 32'hDEAD_BEEF, 32'h58, 1'b1, 32'h0, 1'b0);
        respond("sw", 0, 32'h0, 32'h208, 1'b1, 4'b1111, 32'hDEAD_BEEF, sc);

        // LW aligned and LBU lane 1.
        send(1'b1, 1'b1, 1'b0, MEM_OP_W_, 32'h10C, 32'h0, 32'h5C, 1'b1, 32'h1234_5678, 1'b0);
        respond("lw", 0, 32'h1234_5678, 32'h10C, 1'b0, 4'b1111, 32'h0, sc);
        send(1'b1, 1'b1, 1'b0, MEM_OP_BU, 32'h101, 32'h0, 32'h60, 1'b1, 32'h0000_00A5, 1'b0);
        respond("lbu", 0, 32'h0000_A500, 32'h100, 1'b0, 4'b1111, 32'h0, sc);

        // Read and write both set: behaves as SB to lane 3, no load data.
        send(1'b0, 1'b1, 1'b1, MEM_OP_B, 32'h203, 32'h0000_005A, 32'h64, 1'b1, 32'h0, 1'b0);
        respond("rw_both", 0, 32'hFFFF_FFFF, 32'h200, 1'b1, 4'b1000, 32'h5A5A_5A5A, sc);

        // Misaligned accesses: no request, addr_err record.
        send(1'b1, 1'b1, 1'b0, MEM_OP_W_, 32'h102, 32'h0, 32'h68, 1'b1, 32'h0, 1'b1);
        chk("mis_lw_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_lw_stall", {31'd0, stall}, 32'd0);
        send(1'b1, 1'b1, 1'b0, MEM_OP_HU, 32'h105, 32'h0, 32'h6C, 1'b1, 32'h0, 1'b1);
        chk("mis_lhu_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk);
        #1;

        // Ack while idle is ignored.
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("idle_ack_stall", {31'd0, stall}, 32'd0);
        chk("idle_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("idle_ack_wb_valid", {31'd0, wb_valid}, 32'd0);

        // Reset during BUSY, then a late ack.
        send(1'b1, 1'b1, 1'b0, MEM_OP_W_, 32'h300, 32'h0, 32'h70, 1'b0, 32'h0, 1'b0);
        chk("abort_req_before", {31'd0, dmem_req}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        dmem_ack = 1'b1;
        chk("abort_req", {31'd0, dmem_req}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_be", {28'd0, dmem_be}, 32'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("late_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);
        chk("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
